// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift unit.
// Provides the direction encodings, FSM state encodings, default widths and
// stage-index bounds used by shift_sequencer and shift_stage.
package shift_pkg;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_SHAMT_WIDTH = 5;

   localparam logic DIR_SLL = 1'b0;
   localparam logic DIR_SRA = 1'b1;

   // Stages run from the widest shift (2^4) down to the single-bit shift.
   localparam logic [2:0] STAGE_FIRST = 3'd4;
   localparam logic [2:0] STAGE_LAST  = 3'd0;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/shift_stage.sv
// Single power-of-two shift stage, purely combinational.
//   data_i : value entering the stage
//   k_i    : stage index, shift distance is 2^k_i (k_i in 0..4)
//   dir_i  : DIR_SLL (zero fill) or DIR_SRA (MSB fill)
//   en_i   : 0 passes data_i through unchanged
//   out_o  : stage result
module shift_stage
   import shift_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [2:0]            k_i,
   input  logic                  dir_i,
   input  logic                  en_i,
   output logic [DATA_WIDTH-1:0] out_o
);

   logic [DATA_WIDTH-1:0] sll_16, sll_8, sll_4, sll_2, sll_1;
   logic [DATA_WIDTH-1:0] sra_16, sra_8, sra_4, sra_2, sra_1;

   assign sll_16 = data_i << 16;
   assign sll_8  = data_i << 8;
   assign sll_4  = data_i << 4;
   assign sll_2  = data_i << 2;
   assign sll_1  = data_i << 1;

   // Arithmetic shift replicates the current MSB, so chaining stages keeps the sign.
   assign sra_16 = $unsigned($signed(data_i) >>> 16);
   assign sra_8  = $unsigned($signed(data_i) >>> 8);
   assign sra_4  = $unsigned($signed(data_i) >>> 4);
   assign sra_2  = $unsigned($signed(data_i) >>> 2);
   assign sra_1  = $unsigned($signed(data_i) >>> 1);

   always_comb begin
      out_o = data_i;
      if (en_i) begin
         case (k_i)
            3'd4:    out_o = (dir_i == DIR_SRA) ? sra_16 : sll_16;
            3'd3:    out_o = (dir_i == DIR_SRA) ? sra_8  : sll_8;
            3'd2:    out_o = (dir_i == DIR_SRA) ? sra_4  : sll_4;
            3'd1:    out_o = (dir_i == DIR_SRA) ? sra_2  : sll_2;
            3'd0:    out_o = (dir_i == DIR_SRA) ? sra_1  : sll_1;
            default: out_o = data_i;
         endcase
      end
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter (sll / sra) with a start / result-ready handshake.
// One power-of-two stage is applied per cycle (16, 8, 4, 2, 1), giving a fixed
// six-cycle latency from the start cycle to the data_resultRDY pulse.
//   clock, reset   : clock, synchronous active-high reset
//   ctrl_shift     : start pulse, accepted in IDLE or DONE
//   ctrl_dir       : 0 = sll, 1 = sra
//   ctrl_shamt     : shift amount
//   data_operand   : value to shift
//   data_result    : working register, final while data_resultRDY is high
//   data_resultRDY : one-cycle completion pulse
//   busy           : stages executing
//
// state | meaning
// IDLE  | waiting for start; data_result holds the last result
// RUN   | one stage per cycle, k counts 4 down to 0
// DONE  | result final, data_resultRDY high; may accept a new start
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int SHAMT_WIDTH = DEF_SHAMT_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   ctrl_shift,
   input  logic                   ctrl_dir,
   input  logic [SHAMT_WIDTH-1:0] ctrl_shamt,
   input  logic [DATA_WIDTH-1:0]  data_operand,
   output logic [DATA_WIDTH-1:0]  data_result,
   output logic                   data_resultRDY,
   output logic                   busy
);

   state_e                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  work_q, work_d;
   logic [SHAMT_WIDTH-1:0] shamt_q, shamt_d;
   logic                   dir_q, dir_d;
   logic [2:0]             k_q, k_d;
   logic [DATA_WIDTH-1:0]  stage_out;

   shift_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
      .data_i (work_q),
      .k_i    (k_q),
      .dir_i  (dir_q),
      .en_i   (shamt_q[k_q]),
      .out_o  (stage_out)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         work_q  <= '0;
         shamt_q <= '0;
         dir_q   <= DIR_SLL;
         k_q     <= STAGE_LAST;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         shamt_q <= shamt_d;
         dir_q   <= dir_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      shamt_d = shamt_q;
      dir_d   = dir_q;
      k_d     = k_q;
      case (state_q)
         IDLE, DONE: begin
            if (ctrl_shift) begin
               work_d  = data_operand;
               shamt_d = ctrl_shamt;
               dir_d   = ctrl_dir;
               k_d     = STAGE_FIRST;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            work_d = stage_out;
            if (k_q == STAGE_LAST) begin
               state_d = DONE;
            end else begin
               k_d = k_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign data_result    = work_q;
   assign data_resultRDY = (state_q == DONE);
   assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_shift;
   logic        ctrl_dir;
   logic [4:0]  ctrl_shamt;
   logic [31:0] data_operand;
   logic [31:0] data_result;
   logic        data_resultRDY;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int rdy_pulses = 0;

   shift_sequencer dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_shift     (ctrl_shift),
      .ctrl_dir       (ctrl_dir),
      .ctrl_shamt     (ctrl_shamt),
      .data_operand   (data_operand),
      .data_result    (data_result),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (data_resultRDY) rdy_pulses++;

   // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_start(input logic dir, input logic [4:0] sh, input logic [31:0] op);
      ctrl_shift   = 1'b1;
      ctrl_dir     = dir;
      ctrl_shamt   = sh;
      data_operand = op;
   endtask

   task automatic scramble_inputs();
      ctrl_shift   = 1'b0;
      ctrl_dir     = ~ctrl_dir;
      ctrl_shamt   = ~ctrl_shamt;
      data_operand = ~data_operand;
   endtask

   // Called in cycle 0 of an operation; returns in cycle 6 with the result checked.
   task automatic run_op(input string tag, input logic dir, input logic [4:0] sh,
                         input logic [31:0] op, input logic [31:0] exp, input bit full);
      drive_start(dir, sh, op);
      step();
      scramble_inputs();
      for (int c = 1; c <= 5; c++) begin
         if (full) begin
            chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
            chk({tag, "_rdy_early"}, {31'b0, data_resultRDY}, 32'd0);
         end
         if (c < 5) step();
      end
      step();
      chk({tag, "_rdy"}, {31'b0, data_resultRDY}, 32'd1);
      if (full) chk({tag, "_busy6"}, {31'b0, busy}, 32'd0);
      chk({tag, "_result"}, data_result, exp);
   endtask

   initial begin
      logic [31:0] op, exp;
      logic [4:0]  sh;
      logic        dir;
      int          pulses_before;

      reset = 1'b1; ctrl_shift = 1'b0; ctrl_dir = 1'b0; ctrl_shamt = '0; data_operand = '0;
      step();
      step();
      chk("reset_result", data_result, 32'h0);
      chk("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      reset = 1'b0;
      step();

      run_op("sra16", 1'b1, 5'd16, 32'h8000_0000, 32'hFFFF_8000, 1'b1);
      ctrl_shift = 1'b0;
      step();
      chk("sra16_rdy_once", {31'b0, data_resultRDY}, 32'd0);
      chk("sra16_hold", data_result, 32'hFFFF_8000);

      run_op("sll31", 1'b0, 5'd31, 32'h0000_0001, 32'h8000_0000, 1'b1);
      run_op("sra31", 1'b1, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
      run_op("sra4",  1'b1, 5'd4,  32'hF000_0000, 32'hFF00_0000, 1'b1);
      run_op("sll0",  1'b0, 5'd0,  32'h1234_5678, 32'h1234_5678, 1'b1);
      run_op("sra0",  1'b1, 5'd0,  32'h1234_5678, 32'h1234_5678, 1'b1);
      run_op("sll5",  1'b0, 5'd5,  32'h0F0F_0F0F, 32'hE1E1_E1E0, 1'b0);
      run_op("sra13", 1'b1, 5'd13, 32'h8765_4321, 32'hFFFC_3B2A, 1'b0);
      ctrl_shift = 1'b0;
      step();

      // Start ignored while busy, then a back-to-back start from DONE.
      drive_start(1'b0, 5'd1, 32'h0000_0001);
      step();                                   // cycle 1
      scramble_inputs();
      step();                                   // cycle 2
      step();                                   // cycle 3
      drive_start(1'b1, 5'd7, 32'hDEAD_BEEF);
      step();                                   // cycle 4
      ctrl_shift = 1'b0;
      chk("ignore_busy4", {31'b0, busy}, 32'd1);
      step();                                   // cycle 5
      step();                                   // cycle 6
      chk("b2b_first_rdy", {31'b0, data_resultRDY}, 32'd1);
      chk("b2b_first_result", data_result, 32'h0000_0002);
      run_op("b2b_third", 1'b1, 5'd1, 32'h8000_0000, 32'hC000_0000, 1'b1);
      ctrl_shift = 1'b0;
      step();
      chk("b2b_idle_rdy", {31'b0, data_resultRDY}, 32'd0);
      chk("b2b_idle_busy", {31'b0, busy}, 32'd0);

      // Reset during RUN aborts without a completion pulse.
      pulses_before = rdy_pulses;
      drive_start(1'b1, 5'd8, 32'h8000_0000);
      step();                                   // cycle 1
      ctrl_shift = 1'b0;
      step();                                   // cycle 2
      step();                                   // cycle 3
      reset = 1'b1;
      step();                                   // cycle 4
      reset = 1'b0;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_result", data_result, 32'h0);
      chk("abort_rdy", {31'b0, data_resultRDY}, 32'd0);
      step();                                   // cycle 5
      run_op("after_abort", 1'b0, 5'd16, 32'h0000_FFFF, 32'hFFFF_0000, 1'b1);
      chk("abort_pulse_count", rdy_pulses - pulses_before, 32'd0);
      ctrl_shift = 1'b0;
      step();

      // Random back-to-back operations against a reference shift.
      pulses_before = rdy_pulses;
      for (int i = 0; i < 1000; i++) begin
         op  = $urandom();
         sh  = 5'($urandom_range(0, 31));
         dir = 1'($urandom_range(0, 1));
         exp = dir ? 32'($signed(op) >>> sh) : (op << sh);
         run_op("rand", dir, sh, op, exp, 1'b0);
      end
      ctrl_shift = 1'b0;
      step();
      step();
      chk("rand_pulse_count", rdy_pulses - pulses_before, 32'd1000);
      chk("rand_idle_busy", {31'b0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
